// File: rtl/ahb_sdram_wbuf.sv
// Posted-write buffer between the AHB-Lite interconnect and the SDRAM slave.
// Writes retire into a small FIFO with zero wait states; reads wait for the FIFO to drain.
module ahb_sdram_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic              M_HSEL,
    output logic [31:0]       M_HADDR,
    output logic [1:0]        M_HTRANS,
    output logic              M_HWRITE,
    output logic [2:0]        M_HSIZE,
    output logic [31:0]       M_HWDATA,
    output logic              M_HREADY,
    input  logic              M_HREADYOUT,
    input  logic [31:0]       M_HRDATA
);

    typedef enum logic [2:0] {M_IDLE, M_WADDR, M_WDATA, M_RADDR, M_RDATA} mstate_t;

    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [31:0]      fifo_addr [DEPTH];
    logic [2:0]       fifo_size [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, base_ptr;
    logic [PTR_W:0]   count, base_cnt;

    logic             pend_valid, pend_write;
    logic [31:0]      pend_addr;
    logic [2:0]       pend_size;
    logic             rd_issued, rd_done, rd_resp;
    mstate_t          mstate;

    logic             accept, full, pop, push, rd_req, have_next;
    logic [31:0]      nxt_addr;
    logic [2:0]       nxt_size;
    logic             unused_ok;

    assign unused_ok = ^{HTRANS[0], 1'b0};
    assign HRESP     = 1'b0;
    assign M_HREADY  = M_HREADYOUT;

    // base_* describe the queue after this cycle's pop, so the next address phase can
    // be launched from the following entry (or the entry being pushed right now).
    always_comb begin
        accept    = HSEL && HREADY && HTRANS[1];
        full      = (count == FULL_CNT);
        pop       = (mstate == M_WDATA) && M_HREADYOUT;
        push      = pend_valid && pend_write && (!full || pop);
        rd_req    = pend_valid && !pend_write && !rd_issued;
        HREADYOUT = !pend_valid || (pend_write ? (!full || pop) : rd_resp);
        base_cnt  = pop ? count - CNT_ONE : count;
        base_ptr  = pop ? rd_ptr + PTR_ONE : rd_ptr;
        have_next = (base_cnt != '0) || push;
        nxt_addr  = pend_addr;
        nxt_size  = pend_size;
        if (base_cnt != '0) begin
            nxt_addr = fifo_addr[base_ptr];
            nxt_size = fifo_size[base_ptr];
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_addr[wr_ptr] <= pend_addr;
            fifo_size[wr_ptr] <= pend_size;
            fifo_data[wr_ptr] <= HWDATA;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Upstream slave side: one outstanding data phase, held while HREADYOUT is low.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            pend_size  <= '0;
            rd_resp    <= 1'b0;
        end else begin
            rd_resp <= rd_done;
            if (accept) begin
                pend_valid <= 1'b1;
                pend_write <= HWRITE;
                pend_addr  <= HADDR;
                pend_size  <= HSIZE;
            end else if (HREADYOUT) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            mstate    <= M_IDLE;
            M_HSEL    <= 1'b0;
            M_HTRANS  <= 2'b00;
            M_HWRITE  <= 1'b0;
            M_HADDR   <= '0;
            M_HSIZE   <= '0;
            M_HWDATA  <= '0;
            HRDATA    <= '0;
            rd_done   <= 1'b0;
            rd_issued <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (pend_valid && !pend_write && rd_resp) rd_issued <= 1'b0;
            case (mstate)
                M_IDLE: begin
                    if (rd_req && count == '0) begin
                        mstate    <= M_RADDR;
                        M_HSEL    <= 1'b1;
                        M_HTRANS  <= 2'b10;
                        M_HWRITE  <= 1'b0;
                        M_HADDR   <= pend_addr;
                        M_HSIZE   <= pend_size;
                        rd_issued <= 1'b1;
                    end else if (have_next) begin
                        mstate   <= M_WADDR;
                        M_HSEL   <= 1'b1;
                        M_HTRANS <= 2'b10;
                        M_HWRITE <= 1'b1;
                        M_HADDR  <= nxt_addr;
                        M_HSIZE  <= nxt_size;
                    end
                end
                M_WADDR: begin
                    if (M_HREADYOUT) begin
                        mstate   <= M_WDATA;
                        M_HSEL   <= 1'b0;
                        M_HTRANS <= 2'b00;
                        M_HWDATA <= fifo_data[rd_ptr];
                    end
                end
                M_WDATA: begin
                    if (M_HREADYOUT) begin
                        if (have_next) begin
                            mstate   <= M_WADDR;
                            M_HSEL   <= 1'b1;
                            M_HTRANS <= 2'b10;
                            M_HWRITE <= 1'b1;
                            M_HADDR  <= nxt_addr;
                            M_HSIZE  <= nxt_size;
                        end else begin
                            mstate <= M_IDLE;
                        end
                    end
                end
                M_RADDR: begin
                    if (M_HREADYOUT) begin
                        mstate   <= M_RDATA;
                        M_HSEL   <= 1'b0;
                        M_HTRANS <= 2'b00;
                    end
                end
                M_RDATA: begin
                    if (M_HREADYOUT) begin
                        mstate  <= M_IDLE;
                        HRDATA  <= M_HRDATA;
                        rd_done <= 1'b1;
                    end
                end
                default: mstate <= M_IDLE;
            endcase
        end
    end

endmodule
